conv_stream_host: RTL and testbench

- Host-side master/slave endpoint for the 1-D convolution core; the opposite end of both of its streaming interfaces.
- Buffers one N-sample X vector written by a host or testbench port, then streams it out over a valid/ready master interface into the conv core's X input.
- Collects the N-M+1 Y results from the conv core's valid/ready output into a readable result buffer.
- Pulses done and reports total processing latency.

---
 rtl/conv_host_pkg.sv | 19 +
 rtl/stream_buf_mem.sv | 25 ++
 rtl/conv_stream_host.sv | 137 +++++++++++++
 tb/tb_conv_stream_host.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_host_pkg.sv
// Shared types and default sizing for the conv core host endpoint.
// State encoding plus sample width, vector length and result count.
package conv_host_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_Y,
    DONE
  } state_t;

  localparam int T_DEF   = 8;
  localparam int N_DEF   = 128;
  localparam int M_DEF   = 32;
  localparam int NY_DEF  = N_DEF - M_DEF + 1;
  localparam int XAW_DEF = $clog2(N_DEF);
  localparam int YAW_DEF = $clog2(NY_DEF);

endpackage

// File: rtl/stream_buf_mem.sv
// Register-array sample buffer: one synchronous write port and
// one combinational read port; contents survive reset.
module stream_buf_mem #(
  parameter  int W     = 8,
  parameter  int DEPTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv_stream_host.sv
// Host endpoint for the 1-D conv core: loads and streams an X vector,
// captures the Y results and measures end-to-end latency.
module conv_stream_host
  import conv_host_pkg::*;
#(
  parameter  int T   = T_DEF,
  parameter  int N   = N_DEF,
  parameter  int M   = M_DEF,
  localparam int NY  = N - M + 1,
  localparam int YAW = $clog2(NY)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           host_wr_en,
  input  logic [T-1:0]   host_wr_data,
  input  logic           host_start,
  input  logic [YAW-1:0] host_rd_addr,
  output logic [T-1:0]   host_rd_data,
  output logic           busy,
  output logic           done,
  output logic [31:0]    latency_cycles,
  output logic           m_valid_x,
  input  logic           m_ready_x,
  output logic [T-1:0]   m_data_x,
  input  logic           s_valid_y,
  output logic           s_ready_y,
  input  logic [T-1:0]   s_data_y
);

  localparam int XAW = $clog2(N);
  localparam int PW  = $clog2(N + 1);
  localparam int CW  = $clog2(NY + 1);
  localparam logic [PW-1:0] N_P  = PW'(N);
  localparam logic [CW-1:0] NY_C = CW'(NY);

  state_t         state, state_nxt;
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  ycnt;
  logic           lat_run;
  logic           x_fire, y_fire;
  logic           x_last, y_last, y_all;
  logic           wr_ok, start_ok;
  logic [XAW-1:0] x_raddr;
  logic [T-1:0]   x_rd, y_rd;

  assign busy      = (state == SEND) || (state == WAIT_Y);
  assign done      = (state == DONE);
  assign s_ready_y = busy && (ycnt < NY_C);
  assign x_fire    = m_valid_x && m_ready_x;
  assign y_fire    = s_valid_y && s_ready_y;
  assign x_last    = x_fire && (rptr == N_P - 1'b1);
  assign y_last    = y_fire && (ycnt == NY_C - 1'b1);
  assign y_all     = (ycnt == NY_C) || y_last;
  assign wr_ok     = (state == IDLE) && host_wr_en
                     && (wptr != N_P);
  assign start_ok  = (state == IDLE) && host_start
                     && (wptr == N_P);
  // Prefetch the sample after the current beat
  assign x_raddr   = start_ok ? '0 : XAW'(rptr + 1'b1);

  stream_buf_mem #(.W(T), .DEPTH(N)) u_xbuf (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr[XAW-1:0]),
    .wdata (host_wr_data),
    .raddr (x_raddr),
    .rdata (x_rd)
  );

  stream_buf_mem #(.W(T), .DEPTH(NY)) u_ybuf (
    .clk   (clk),
    .we    (y_fire),
    .waddr (ycnt[YAW-1:0]),
    .wdata (s_data_y),
    .raddr (host_rd_addr),
    .rdata (y_rd)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = SEND;
      SEND:    if (x_last)
                 state_nxt = y_all ? DONE : WAIT_Y;
      WAIT_Y:  if (y_all) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wptr           <= '0;
      rptr           <= '0;
      ycnt           <= '0;
      m_valid_x      <= 1'b0;
      m_data_x       <= '0;
      host_rd_data   <= '0;
      lat_run        <= 1'b0;
      latency_cycles <= '0;
    end else begin
      state        <= state_nxt;
      host_rd_data <= (32'(host_rd_addr) < NY) ? y_rd : '0;
      if (wr_ok)
        wptr <= wptr + 1'b1;
      if (start_ok) begin
        m_valid_x <= 1'b1;
        m_data_x  <= x_rd;
      end else if (x_fire) begin
        rptr <= rptr + 1'b1;
        if (x_last)
          m_valid_x <= 1'b0;
        else
          m_data_x <= x_rd;
      end
      if (y_fire)
        ycnt <= ycnt + 1'b1;
      if (state == DONE) begin
        wptr <= '0;
        rptr <= '0;
        ycnt <= '0;
      end
      // First X beat counts as cycle 1; last Y beat closes the window
      if (x_fire && rptr == '0) begin
        latency_cycles <= 32'd1;
        lat_run        <= 1'b1;
      end else if (lat_run) begin
        if (latency_cycles != '1)
          latency_cycles <= latency_cycles + 1'b1;
        if (y_last)
          lat_run <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_host.sv
// Directed bench for conv_stream_host: loads, streams, captures
// results and checks handshakes, done timing and latency.
module tb_conv_stream_host;

  localparam int N  = 128;
  localparam int NY = 97;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_wr_en = 1'b0;
  logic [7:0]  host_wr_data = '0;
  logic        host_start = 1'b0;
  logic [6:0]  host_rd_addr = '0;
  logic [7:0]  host_rd_data;
  logic        busy, done;
  logic [31:0] latency_cycles;
  logic        m_valid_x;
  logic        m_ready_x = 1'b0;
  logic [7:0]  m_data_x;
  logic        s_valid_y = 1'b0;
  logic        s_ready_y;
  logic [7:0]  s_data_y = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  conv_stream_host dut (
    .clk            (clk),
    .reset          (reset),
    .host_wr_en     (host_wr_en),
    .host_wr_data   (host_wr_data),
    .host_start     (host_start),
    .host_rd_addr   (host_rd_addr),
    .host_rd_data   (host_rd_data),
    .busy           (busy),
    .done           (done),
    .latency_cycles (latency_cycles),
    .m_valid_x      (m_valid_x),
    .m_ready_x      (m_ready_x),
    .m_data_x       (m_data_x),
    .s_valid_y      (s_valid_y),
    .s_ready_y      (s_ready_y),
    .s_data_y       (s_data_y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic load(input int count, input int base);
    for (int i = 0; i < count; i++) begin
      host_wr_en   = 1'b1;
      host_wr_data = 8'(base + i);
      @(posedge clk); #1;
    end
    host_wr_en = 1'b0;
  endtask

  int xbeats, ybeats, dones, first_x, last_x, last_y, done_k;
  int seq_err, stall_err, extra_err, busy_err;

  task automatic run_xfer(input string nm, input int xbase,
                          input int ybase, input bit toggle);
    int k, ysent, gap, exp_done;
    bit y_pend, stalled;
    logic [7:0] held;
    xbeats = 0; ybeats = 0; dones = 0; done_k = -1;
    first_x = -1; last_x = -1; last_y = -1;
    seq_err = 0; stall_err = 0; extra_err = 0; busy_err = 0;
    ysent = 0; gap = 0; y_pend = 0; stalled = 0; held = '0;
    host_start = 1'b1;
    @(posedge clk); #1;
    host_start = 1'b0;
    k = 0;
    while (k < 2000 && !(dones > 0 && k > done_k + 3)) begin
      m_ready_x = toggle ? (k % 2 == 0) : 1'b1;
      if (!y_pend && ysent < NY && xbeats >= 32) begin
        if (gap > 0) gap--;
        else begin
          y_pend   = 1'b1;
          s_data_y = 8'(ybase + ysent);
          ysent++;
          gap = int'($urandom_range(1, 3));
        end
      end
      s_valid_y = y_pend;
      #1;
      if (done === 1'b1) begin
        dones++;
        done_k = k;
      end else if (dones == 0 && busy !== 1'b1) busy_err++;
      if (stalled && (m_valid_x !== 1'b1 || m_data_x !== held))
        stall_err++;
      stalled = 1'b0;
      if (m_valid_x === 1'b1) begin
        if (xbeats >= N) extra_err++;
        if (m_ready_x) begin
          if (m_data_x !== 8'(xbase + xbeats)) seq_err++;
          if (xbeats == 0) first_x = k;
          last_x = k;
          xbeats++;
        end else begin
          stalled = 1'b1;
          held    = m_data_x;
        end
      end
      if (s_valid_y && s_ready_y === 1'b1) begin
        ybeats++;
        last_y = k;
        y_pend = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    m_ready_x = 1'b0;
    s_valid_y = 1'b0;
    exp_done = ((last_x > last_y) ? last_x : last_y) + 1;
    chk({nm, "_finished"}, 32'(dones > 0), 32'd1);
    chk({nm, "_xbeats"}, xbeats, N);
    chk({nm, "_xorder"}, seq_err, 0);
    chk({nm, "_xstall_hold"}, stall_err, 0);
    chk({nm, "_xafter_last"}, extra_err, 0);
    chk({nm, "_xspan"}, last_x - first_x, toggle ? 254 : 127);
    chk({nm, "_ybeats"}, ybeats, NY);
    chk({nm, "_done_once"}, dones, 1);
    chk({nm, "_done_cycle"}, done_k, exp_done);
    chk({nm, "_busy"}, busy_err, 0);
    chk({nm, "_latency"}, latency_cycles, last_y - first_x + 1);
    s_valid_y = 1'b1;
    #1;
    chk({nm, "_y_idle_nack"}, s_ready_y, 0);
    s_valid_y = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [6:0] addr;
    logic       start;
    logic [7:0] exp_rd;
  } rd_vec_t;

  rd_vec_t rtab[8];

  initial begin
    rtab[0] = '{"rd_a0",   7'd0,   1'b0, 8'd5};
    rtab[1] = '{"rd_a1",   7'd1,   1'b1, 8'd6};
    rtab[2] = '{"rd_a50",  7'd50,  1'b0, 8'd55};
    rtab[3] = '{"rd_a95",  7'd95,  1'b1, 8'd100};
    rtab[4] = '{"rd_a96",  7'd96,  1'b0, 8'd101};
    rtab[5] = '{"rd_a97",  7'd97,  1'b0, 8'd0};
    rtab[6] = '{"rd_a100", 7'd100, 1'b1, 8'd0};
    rtab[7] = '{"rd_a127", 7'd127, 1'b0, 8'd0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_m_valid_x", m_valid_x, 0);
    chk("rst_s_ready_y", s_ready_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_m_data_x", m_data_x, 0);
    chk("rst_rd_data", host_rd_data, 0);
    chk("rst_latency", latency_cycles, 0);
    host_start = 1'b1;
    @(posedge clk); #1;
    host_start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_valid", m_valid_x, 0);

    load(127, 0);
    host_wr_en   = 1'b1;
    host_wr_data = 8'd127;
    host_start   = 1'b1;
    @(posedge clk); #1;
    host_wr_en = 1'b0;
    host_start = 1'b0;
    chk("wr_start_same_busy", busy, 0);
    chk("wr_start_same_valid", m_valid_x, 0);
    run_xfer("full", 0, 5, 1'b0);

    foreach (rtab[i]) begin
      host_rd_addr = rtab[i].addr;
      host_start   = rtab[i].start;
      @(posedge clk); #1;
      host_start = 1'b0;
      chk(rtab[i].name, host_rd_data, rtab[i].exp_rd);
      chk({rtab[i].name, "_idle"}, busy, 0);
    end

    load(N, 8'h40);
    run_xfer("bp", 8'h40, 20, 1'b1);
    host_rd_addr = 7'd0;
    @(posedge clk); #1;
    chk("bp_rd_a0", host_rd_data, 20);

    load(100, 8'h10);
    host_start = 1'b1;
    @(posedge clk); #1;
    host_start = 1'b0;
    repeat (3) begin
      chk("short_start_valid", m_valid_x, 0);
      chk("short_start_busy", busy, 0);
      @(posedge clk); #1;
    end
    load(30, 8'h10 + 100);
    run_xfer("ovf", 8'h10, 30, 1'b0);

    load(N, 8'h20);
    host_start = 1'b1;
    @(posedge clk); #1;
    host_start = 1'b0;
    m_ready_x  = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("abort_pre_data", m_data_x, 8'h20 + 40);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", m_valid_x, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready_y", s_ready_y, 0);
    reset     = 1'b0;
    m_ready_x = 1'b0;
    load(N, 8'h70);
    run_xfer("post_abort", 8'h70, 40, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
